// File: rtl/vec_store_serializer.sv
// -----------------------------------------------------------------------------
// vec_store_serializer
//
// Purpose:
//   Takes one V-lane vector ALU result (V lanes of N bits) through a
//   valid/ready handshake, buffers it, and writes it out one lane per memory
//   transaction over a single N-bit write port. Lane k goes to word address
//   base+k (modulo 2^AW). A one-cycle done pulse follows the last
//   acknowledged write.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   in_valid        upstream presents a vector
//   in_ready        block can accept a vector this cycle
//   in_data         lane data, lane 0 at index 0
//   in_base         word address for lane 0
//   in_mask         (VEC_STORE_MASK_EN only) per-lane write enable
//   mem_we          write request, held until mem_ack
//   mem_addr        write word address
//   mem_wdata       write data
//   mem_ack         memory accepts the current write this cycle
//   busy            a vector is held or being written
//   done            one-cycle pulse after the last lane write is acked
//
// Configuration:
//   `define VEC_STORE_MASK_EN adds in_mask. Lanes with a 0 mask bit are
//   skipped without spending a cycle; an all-zero mask goes straight from
//   accept to DONE. Without the macro every lane is written.
// -----------------------------------------------------------------------------
module vec_store_serializer #(
    parameter int N  = 20,
    parameter int V  = 8,
    parameter int AW = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [V-1:0][N-1:0] in_data,
    input  logic [AW-1:0]       in_base,
`ifdef VEC_STORE_MASK_EN
    input  logic [V-1:0]        in_mask,
`endif
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [N-1:0]        mem_wdata,
    input  logic                mem_ack,
    output logic                busy,
    output logic                done
);

    localparam int LW = (V > 1) ? $clog2(V) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_q,     state_d;
    logic [LW-1:0]       lane_q,      lane_d;
    logic [V-1:0][N-1:0] buf_q,       buf_d;
    logic [AW-1:0]       base_q,      base_d;
    logic                in_ready_q,  in_ready_d;
    logic                mem_we_q,    mem_we_d;
    logic [AW-1:0]       mem_addr_q,  mem_addr_d;
    logic [N-1:0]        mem_wdata_q, mem_wdata_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // Lane enables: new_en for the vector on the input, lane_en for the one
    // held in the buffer.
    logic [V-1:0] new_en;
    logic [V-1:0] lane_en;

`ifdef VEC_STORE_MASK_EN
    logic [V-1:0] mask_q, mask_d;
    assign new_en  = in_mask;
    assign lane_en = mask_q;
`else
    assign new_en  = '1;
    assign lane_en = '1;
`endif

    // Lowest enabled lane at index >= from, returned as {found, index}.
    // Searching downwards lets the lowest match overwrite higher ones.
    function automatic logic [LW:0] find_set(input logic [V-1:0] en, input int from);
        logic [LW:0] r;
        r = '0;
        for (int i = V - 1; i >= 0; i--) begin
            if (i >= from && en[i]) r = {1'b1, LW'(i)};
        end
        return r;
    endfunction

    logic          accept;
    logic          first_found, next_found;
    logic [LW-1:0] first_idx,   next_idx;

    assign accept = in_valid && in_ready_q;
    assign {first_found, first_idx} = find_set(new_en, 0);
    assign {next_found,  next_idx}  = find_set(lane_en, int'(lane_q) + 1);

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        base_d      = base_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef VEC_STORE_MASK_EN
        mask_d      = mask_q;
`endif

        case (state_q)
            // DONE accepts exactly like IDLE so vectors can stream back to back.
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    buf_d  = in_data;
                    base_d = in_base;
`ifdef VEC_STORE_MASK_EN
                    mask_d = in_mask;
`endif
                    if (first_found) begin
                        // First write is presented in the cycle right after accept.
                        state_d     = WRITE;
                        lane_d      = first_idx;
                        in_ready_d  = 1'b0;
                        busy_d      = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = in_base + AW'(first_idx);
                        mem_wdata_d = in_data[first_idx];
                    end else begin
                        // Nothing enabled: no write, pulse done next cycle.
                        state_d = DONE;
                        lane_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            WRITE: begin
                // Outputs only move on an acknowledged write; a stall simply
                // holds everything.
                if (mem_ack) begin
                    if (next_found) begin
                        lane_d      = next_idx;
                        mem_addr_d  = base_q + AW'(next_idx);
                        mem_wdata_d = buf_q[next_idx];
                    end else begin
                        state_d    = DONE;
                        mem_we_d   = 1'b0;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
                mem_we_d   = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            buf_q       <= '0;
            base_q      <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef VEC_STORE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            base_q      <= base_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef VEC_STORE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
